// File: rtl/float_to_fix_pipe_if.sv
// Stream bundle for the float-to-fixed converter: input word side and result side.
// The bench drives through "master"; the converter attaches through "slave".
interface float_to_fix_pipe_if #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int TAG_WIDTH   = 2
);
    localparam int W = INT_WIDTH + FRACT_WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_data;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 in_round;

    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_ovf;
    logic                 out_nan;
    logic                 out_inexact;

    modport master (
        output in_valid, in_data, in_tag, in_round, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_ovf, out_nan, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_tag, in_round, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_ovf, out_nan, out_inexact
    );
endinterface

// File: rtl/float_to_fix_pipe.sv
// Three-stage signed IEEE-754 single to two's-complement fixed-point converter
// (unpack/classify, align, round/saturate/negate) with a stall-all valid/ready stream.
module float_to_fix_pipe #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int TAG_WIDTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    float_to_fix_pipe_if.slave bus
);
    localparam int W = INT_WIDTH + FRACT_WIDTH;

    localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_OUT = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_OUT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_NAN  = 2'd2,
        CLS_SAT  = 2'd3
    } cls_e;

    // OR of the lowest n mantissa bits: the part that falls below the output LSB.
    function automatic logic lost_bits(input logic [22:0] mant, input int n);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i < n) begin
                acc = acc | mant[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    logic                 adv_s;

    logic [7:0]           exp_s;
    logic [22:0]          mant_s;
    logic signed [9:0]    e_s;
    cls_e                 cls_s;
    logic                 pre_inx_s;

    logic                 v1_r;
    logic                 sign1_r;
    logic                 round1_r;
    logic                 pre_inx1_r;
    logic [TAG_WIDTH-1:0] tag1_r;
    cls_e                 cls1_r;
    logic signed [9:0]    e1_r;
    logic [23:0]          sig1_r;

    int                   sh_s;
    int                   rsh_s;
    logic [63:0]          ext_s;
    logic [63:0]          shifted_s;
    logic [W-1:0]         mag_s;
    logic                 guard_s;
    logic                 sticky_s;

    logic                 v2_r;
    logic                 sign2_r;
    logic                 round2_r;
    logic                 pre_inx2_r;
    logic [TAG_WIDTH-1:0] tag2_r;
    cls_e                 cls2_r;
    logic [W-1:0]         mag2_r;
    logic                 guard2_r;
    logic                 sticky2_r;

    logic                 inc_s;
    logic [W:0]           mag_rnd_s;
    logic [W:0]           neg_s;
    logic [W-1:0]         data_s;
    logic                 ovf_s;
    logic                 nan_s;
    logic                 inx_s;

    logic                 out_valid_r;
    logic [W-1:0]         out_data_r;
    logic [TAG_WIDTH-1:0] out_tag_r;
    logic                 out_ovf_r;
    logic                 out_nan_r;
    logic                 out_inexact_r;

    logic                 unused_s;

    assign adv_s        = !out_valid_r || bus.out_ready;
    assign bus.in_ready = adv_s;

    assign exp_s  = bus.in_data[30:23];
    assign mant_s = bus.in_data[22:0];
    assign e_s    = $signed({2'b00, exp_s}) - 10'sd127;

    // S1 classification of the incoming word.
    always_comb begin
        cls_s     = CLS_NORM;
        pre_inx_s = 1'b0;
        if (exp_s == 8'd0) begin
            cls_s     = CLS_ZERO;
            pre_inx_s = |mant_s;
        end else if (exp_s == 8'hFF) begin
            if (mant_s != 23'd0) begin
                cls_s = CLS_NAN;
            end else begin
                cls_s = CLS_SAT;
            end
        end else if (int'(e_s) >= INT_WIDTH) begin
            cls_s     = CLS_SAT;
            pre_inx_s = lost_bits(mant_s, 32'sd23 - FRACT_WIDTH - int'(e_s));
        end else begin
            cls_s     = CLS_NORM;
            pre_inx_s = 1'b0;
        end
    end

    // S1 register: captures the word only on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r       <= 1'b0;
            sign1_r    <= 1'b0;
            round1_r   <= 1'b0;
            pre_inx1_r <= 1'b0;
            tag1_r     <= {TAG_WIDTH{1'b0}};
            cls1_r     <= CLS_NORM;
            e1_r       <= 10'sd0;
            sig1_r     <= 24'd0;
        end else if (adv_s) begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                sign1_r    <= bus.in_data[31];
                round1_r   <= bus.in_round;
                pre_inx1_r <= pre_inx_s;
                tag1_r     <= bus.in_tag;
                cls1_r     <= cls_s;
                e1_r       <= e_s;
                sig1_r     <= {1'b1, mant_s};
            end
        end
    end

    // S2 alignment; significand sits at bit 32 so bits 31 and below are guard/sticky.
    always_comb begin
        sh_s      = int'(e1_r) - 32'sd23 + FRACT_WIDTH;
        rsh_s     = -sh_s;
        ext_s     = {8'd0, sig1_r, 32'd0};
        shifted_s = 64'd0;
        if (sh_s >= 32'sd0) begin
            shifted_s = ext_s << sh_s[5:0];
        end else if (sh_s >= -32'sd24) begin
            shifted_s = ext_s >> rsh_s[5:0];
        end else begin
            shifted_s = 64'd0;
        end
        if (sh_s < -32'sd24) begin
            mag_s    = {W{1'b0}};
            guard_s  = 1'b0;
            sticky_s = 1'b1;
        end else begin
            mag_s    = shifted_s[32 +: W];
            guard_s  = shifted_s[31];
            sticky_s = |shifted_s[30:0];
        end
    end

    // S2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r       <= 1'b0;
            sign2_r    <= 1'b0;
            round2_r   <= 1'b0;
            pre_inx2_r <= 1'b0;
            tag2_r     <= {TAG_WIDTH{1'b0}};
            cls2_r     <= CLS_NORM;
            mag2_r     <= {W{1'b0}};
            guard2_r   <= 1'b0;
            sticky2_r  <= 1'b0;
        end else if (adv_s) begin
            v2_r       <= v1_r;
            sign2_r    <= sign1_r;
            round2_r   <= round1_r;
            pre_inx2_r <= pre_inx1_r;
            tag2_r     <= tag1_r;
            cls2_r     <= cls1_r;
            mag2_r     <= mag_s;
            guard2_r   <= guard_s;
            sticky2_r  <= sticky_s;
        end
    end

    assign inc_s     = round2_r && guard2_r && (sticky2_r || mag2_r[0]);
    assign mag_rnd_s = {1'b0, mag2_r} + {{W{1'b0}}, inc_s};
    assign neg_s     = ~mag_rnd_s + {{W{1'b0}}, 1'b1};

    // S3 rounding, saturation and sign application.
    always_comb begin
        data_s = {W{1'b0}};
        ovf_s  = 1'b0;
        nan_s  = 1'b0;
        inx_s  = 1'b0;
        case (cls2_r)
            CLS_NORM: begin
                inx_s = guard2_r || sticky2_r;
                if (!sign2_r && (mag_rnd_s > POS_LIM)) begin
                    data_s = MAX_OUT;
                    ovf_s  = 1'b1;
                end else if (sign2_r && (mag_rnd_s > NEG_LIM)) begin
                    data_s = MIN_OUT;
                    ovf_s  = 1'b1;
                end else if (sign2_r) begin
                    data_s = neg_s[W-1:0];
                end else begin
                    data_s = mag_rnd_s[W-1:0];
                end
            end
            CLS_ZERO: begin
                inx_s = pre_inx2_r;
            end
            CLS_NAN: begin
                nan_s = 1'b1;
            end
            CLS_SAT: begin
                data_s = sign2_r ? MIN_OUT : MAX_OUT;
                ovf_s  = 1'b1;
                inx_s  = pre_inx2_r;
            end
            default: begin
                data_s = {W{1'b0}};
                ovf_s  = 1'b0;
                nan_s  = 1'b0;
                inx_s  = 1'b0;
            end
        endcase
    end

    // S3 output register; bubbles leave zeroed data and flags behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= {W{1'b0}};
            out_tag_r     <= {TAG_WIDTH{1'b0}};
            out_ovf_r     <= 1'b0;
            out_nan_r     <= 1'b0;
            out_inexact_r <= 1'b0;
        end else if (adv_s) begin
            out_valid_r   <= v2_r;
            out_data_r    <= v2_r ? data_s : {W{1'b0}};
            out_tag_r     <= tag2_r;
            out_ovf_r     <= v2_r && ovf_s;
            out_nan_r     <= v2_r && nan_s;
            out_inexact_r <= v2_r && inx_s;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_tag     = out_tag_r;
    assign bus.out_ovf     = out_ovf_r;
    assign bus.out_nan     = out_nan_r;
    assign bus.out_inexact = out_inexact_r;

    assign unused_s = ^{shifted_s, neg_s[W]};
endmodule

// File: tb/tb_float_to_fix_pipe.sv
// Directed bench for float_to_fix_pipe at defaults (W = 16): conversions, rounding,
// saturation, specials, backpressure and mid-stream reset.
module tb_float_to_fix_pipe;
    localparam int INT_WIDTH   = 12;
    localparam int FRACT_WIDTH = 4;
    localparam int TAG_WIDTH   = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    float_to_fix_pipe_if #(.INT_WIDTH(INT_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

    float_to_fix_pipe #(.INT_WIDTH(INT_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Presents one word, then waits (bounded) for its result; lat = -1 on timeout.
    task automatic run_one(input logic [31:0] d, input logic [1:0] t, input logic r,
                           output logic [15:0] od, output logic [1:0] ot,
                           output logic [2:0] ofl, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_tag   = t;
        bus.in_round = r;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        od  = bus.out_data;
        ot  = bus.out_tag;
        ofl = {bus.out_ovf, bus.out_nan, bus.out_inexact};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.out_data !== 16'h0000 || bus.out_tag !== 2'd0) begin
            tests_failed++; $display("FAIL reset_data: got %h/%0d expected 0000/0", bus.out_data, bus.out_tag);
        end
        tests_run++;
        if ({bus.out_ovf, bus.out_nan, bus.out_inexact} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 000", {bus.out_ovf, bus.out_nan, bus.out_inexact});
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] vin [3]  = '{32'h3FC00000, 32'hC0300000, 32'h80000000};
        logic [15:0] vexp [3] = '{16'h0018, 16'hFFD4, 16'h0000};
        logic [1:0]  vtag [3] = '{2'd2, 2'd1, 2'd3};
        logic [15:0] od; logic [1:0] ot; logic [2:0] ofl; int lat;
        for (int i = 0; i < 3; i++) begin
            run_one(vin[i], vtag[i], 1'b1, od, ot, ofl, lat);
            tests_run++;
            if (od !== vexp[i]) begin
                tests_failed++; $display("FAIL basic_data[%0d]: got %h expected %h", i, od, vexp[i]);
            end
            tests_run++;
            if (ot !== vtag[i]) begin
                tests_failed++; $display("FAIL basic_tag[%0d]: got %0d expected %0d", i, ot, vtag[i]);
            end
            tests_run++;
            if (ofl !== 3'b000) begin
                tests_failed++; $display("FAIL basic_flags[%0d]: got %b expected 000", i, ofl);
            end
            tests_run++;
            if (lat !== 3) begin
                tests_failed++; $display("FAIL basic_latency[%0d]: got %0d expected 3", i, lat);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vin [6]  = '{32'h3DC00000, 32'h3D000000, 32'h3DC00000, 32'h3D000000, 32'hBDC00000, 32'hBD000000};
        logic        vrnd [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] vexp [6] = '{16'h0002, 16'h0000, 16'h0001, 16'h0000, 16'hFFFE, 16'h0000};
        logic [15:0] od; logic [1:0] ot; logic [2:0] ofl; int lat;
        for (int i = 0; i < 6; i++) begin
            run_one(vin[i], 2'd0, vrnd[i], od, ot, ofl, lat);
            tests_run++;
            if (od !== vexp[i]) begin
                tests_failed++; $display("FAIL round_data[%0d]: got %h expected %h", i, od, vexp[i]);
            end
            tests_run++;
            if (ofl !== 3'b001) begin
                tests_failed++; $display("FAIL round_flags[%0d]: got %b expected 001", i, ofl);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vin [6]  = '{32'h45800000, 32'hC5000000, 32'h44FFFF00, 32'h44FFFF00, 32'hC5000100, 32'h45800001};
        logic        vrnd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] vexp [6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};
        logic [2:0]  vfl [6]  = '{3'b100, 3'b000, 3'b101, 3'b001, 3'b100, 3'b101};
        logic [15:0] od; logic [1:0] ot; logic [2:0] ofl; int lat;
        for (int i = 0; i < 6; i++) begin
            run_one(vin[i], 2'd1, vrnd[i], od, ot, ofl, lat);
            tests_run++;
            if (od !== vexp[i]) begin
                tests_failed++; $display("FAIL sat_data[%0d]: got %h expected %h", i, od, vexp[i]);
            end
            tests_run++;
            if (ofl !== vfl[i]) begin
                tests_failed++; $display("FAIL sat_flags[%0d]: got %b expected %b", i, ofl, vfl[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] vin [5]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h00000000};
        logic [15:0] vexp [5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
        logic [2:0]  vfl [5]  = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
        logic [15:0] od; logic [1:0] ot; logic [2:0] ofl; int lat;
        for (int i = 0; i < 5; i++) begin
            run_one(vin[i], 2'd3, 1'b1, od, ot, ofl, lat);
            tests_run++;
            if (od !== vexp[i]) begin
                tests_failed++; $display("FAIL special_data[%0d]: got %h expected %h", i, od, vexp[i]);
            end
            tests_run++;
            if (ofl !== vfl[i]) begin
                tests_failed++; $display("FAIL special_flags[%0d]: got %b expected %b", i, ofl, vfl[i]);
            end
        end
    endtask

    // Eight words 1.0..8.0 (expected k*16) streamed back to back with a 5-cycle stall.
    task automatic test_backpressure();
        logic [31:0] words [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        int          tx = 0;
        int          rx = 0;
        logic        stall_prev = 1'b0;
        logic [15:0] held_d = 16'h0000;
        logic [1:0]  held_t = 2'd0;
        logic [15:0] exp_d;
        logic [1:0]  exp_t;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 5 && cyc < 10);
            bus.in_round  = 1'b1;
            if (tx < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data  = words[tx];
                bus.in_tag   = tx[1:0];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held_d || bus.out_tag !== held_t) begin
                    tests_failed++;
                    $display("FAIL bp_hold: got v=%b %h/%0d expected v=1 %h/%0d",
                             bus.out_valid, bus.out_data, bus.out_tag, held_d, held_t);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                tests_run++;
                if (bus.in_ready !== 1'b0) begin
                    tests_failed++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                tests_run++;
                if (rx < 8) begin
                    exp_d = 16'((rx + 1) * 16);
                    exp_t = rx[1:0];
                    if (bus.out_data !== exp_d || bus.out_tag !== exp_t) begin
                        tests_failed++;
                        $display("FAIL bp_word[%0d]: got %h/%0d expected %h/%0d",
                                 rx, bus.out_data, bus.out_tag, exp_d, exp_t);
                    end
                end else begin
                    tests_failed++;
                    $display("FAIL bp_extra: got %h/%0d expected no more words", bus.out_data, bus.out_tag);
                end
                rx++;
            end
            stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            held_d     = bus.out_data;
            held_t     = bus.out_tag;
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) tx++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests_run++;
        if (rx !== 8) begin
            tests_failed++; $display("FAIL bp_count: got %0d expected 8", rx);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] words [3] = '{32'h40000000, 32'h40400000, 32'h40800000};
        logic [15:0] od; logic [1:0] ot; logic [2:0] ofl; int lat;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_round  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            bus.in_tag   = 2'(i);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL midrst_flushed[%0d]: got %h emitted expected none", i, bus.out_data);
            end
        end
        run_one(32'h3FC00000, 2'd1, 1'b1, od, ot, ofl, lat);
        tests_run++;
        if (od !== 16'h0018 || ot !== 2'd1) begin
            tests_failed++; $display("FAIL midrst_after: got %h/%0d expected 0018/1", od, ot);
        end
        tests_run++;
        if (lat !== 3) begin
            tests_failed++; $display("FAIL midrst_latency: got %0d expected 3", lat);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h00000000;
        bus.in_tag    = 2'd0;
        bus.in_round  = 1'b1;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_specials();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
